preset_timer: RTL and testbench

Memory-mapped 32-bit down-counting timer that sits on the CPU's peripheral bridge. Software programs a preset value and a control word. The timer counts the preset down to zero and raises an interrupt request to the CPU interrupt controller. It supports a one-shot mode and an auto-reload mode.

---
 rtl/preset_timer_pkg.sv | 26 ++
 rtl/preset_timer_fsm.sv | 79 +++++++
 rtl/preset_timer.sv | 84 ++++++++
 tb/tb_preset_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/preset_timer_pkg.sv
// Shared constants and types for the preset_timer peripheral.
// The build macro PRESET_TIMER_AUTO_RELOAD_EN (used by the top) enables auto-reload mode.
package preset_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_AUTO    = 2'b01
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/preset_timer_fsm.sv
// Countdown sequencer for preset_timer: owns the state, COUNT and the pending flag.
module preset_timer_fsm
  import preset_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_reload,
  input  logic [31:0] preset,
  input  logic        pend_clr,
  output logic [31:0] count,
  output logic        pend,
  output logic        en_clr
);

  state_e      state_q, state_d;
  logic [31:0] count_d;
  logic        pend_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count   <= '0;
      pend    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      count   <= count_d;
      pend    <= pend_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    count_d = count;
    pend_d  = pend_clr ? 1'b0 : pend;
    en_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count > 32'd1) begin
          count_d = count - 32'd1;
        end else begin
          // Setting beats a same-cycle CPU clear so no expiry is lost.
          count_d = '0;
          pend_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          pend_d = 1'b0;
          // Reloading here rather than in a LOAD cycle keeps the period at N+1.
          if (en) begin
            count_d = preset;
            state_d = CNT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/preset_timer.sv
// Memory-mapped 32-bit down-counting timer with level interrupt.
// Define PRESET_TIMER_AUTO_RELOAD_EN to enable auto-reload mode (MODE = 01).
module preset_timer
  import preset_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic        en_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [1:0]  mode_rd;
  logic        auto_reload;
  logic        wr_ctrl, wr_preset;
  logic [31:0] count;
  logic        pend;
  logic        en_clr;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

`ifdef PRESET_TIMER_AUTO_RELOAD_EN
  logic [1:0] mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mode_q <= MODE_ONESHOT;
    else if (wr_ctrl) mode_q <= din[CTRL_MODE_MSB:CTRL_MODE_LSB];
  end

  assign mode_rd     = mode_q;
  assign auto_reload = (mode_q == MODE_AUTO);
`else
  assign mode_rd     = 2'b00;
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      preset_q <= '0;
    end else begin
      // A CPU write to CTRL overrides the FSM's one-shot EN clear.
      if (wr_ctrl) begin
        en_q <= din[CTRL_EN];
        im_q <= din[CTRL_IM];
      end else if (en_clr) begin
        en_q <= 1'b0;
      end
      if (wr_preset) preset_q <= din;
    end
  end

  preset_timer_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .en          (en_q),
    .auto_reload (auto_reload),
    .preset      (preset_q),
    .pend_clr    (wr_ctrl || wr_preset),
    .count       (count),
    .pend        (pend),
    .en_clr      (en_clr)
  );

  always_comb begin
    dout = '0;
    unique case (addr)
      ADDR_CTRL:   dout = {28'd0, im_q, mode_rd, en_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count;
      default:     dout = '0;
    endcase
  end

  assign irq = pend & im_q;

endmodule

// File: tb/tb_preset_timer.sv
// Directed self-checking bench for preset_timer; expected values are hand-derived.
module tb_preset_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  preset_timer dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one write; returns at the falling edge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    // Reset held: everything reads zero.
    step(3);
    chk_reg("rst_ctrl", 2'd0, 32'd0);
    chk_reg("rst_preset", 2'd1, 32'd0);
    chk_reg("rst_count", 2'd2, 32'd0);
    chk_irq("rst_irq", 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Idle: PRESET writes alone never start the counter.
    addr = 2'd1; din = 32'd15; we = 1'b1;
    step(20);
    we = 1'b0;
    chk_reg("idle_preset", 2'd1, 32'd15);
    chk_reg("idle_count", 2'd2, 32'd0);
    chk_irq("idle_irq", 1'b0);

    // One-shot, N = 15.
    wr(2'd0, 32'h9);
    chk_reg("os_ctrl_wr", 2'd0, 32'h9);
    step(2);
    chk_reg("os_e2", 2'd2, 32'd15);
    step(1);
    chk_reg("os_e3", 2'd2, 32'd14);
    step(13);
    chk_reg("os_e16", 2'd2, 32'd1);
    chk_irq("os_e16_irq", 1'b0);
    step(1);
    chk_reg("os_e17", 2'd2, 32'd0);
    chk_irq("os_e17_irq", 1'b1);
    step(1);
    chk_reg("os_en_clr", 2'd0, 32'h8);
    chk_irq("os_irq_hold", 1'b1);
    chk_reg("os_count_hold", 2'd2, 32'd0);

    // Re-arm clears the interrupt and restarts.
    wr(2'd0, 32'h9);
    chk_irq("rearm_irq", 1'b0);
    step(2);
    chk_reg("rearm_e2", 2'd2, 32'd15);
    step(3);
    chk_reg("rearm_e5", 2'd2, 32'd12);

    // Clearing EN mid-count: the write edge still decrements, then COUNT freezes.
    wr(2'd0, 32'h8);
    chk_reg("dis_count", 2'd2, 32'd11);
    step(5);
    chk_reg("dis_frozen", 2'd2, 32'd11);

    // Masked expiry, then a CTRL write setting IM clears PEND.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    step(5);
    chk_reg("mask_count", 2'd2, 32'd0);
    chk_irq("mask_irq", 1'b0);
    step(1);
    chk_reg("mask_en_clr", 2'd0, 32'h0);
    wr(2'd0, 32'h9);
    chk_irq("mask_unmask_irq", 1'b0);
    step(5);
    chk_irq("mask_rerun_irq", 1'b1);

    // PRESET write clears PEND; then PRESET = 0 expires after 3 edges.
    wr(2'd1, 32'd0);
    chk_irq("pclr_irq", 1'b0);
    chk_reg("pclr_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h9);
    step(2);
    chk_irq("p0_e2_irq", 1'b0);
    step(1);
    chk_irq("p0_e3_irq", 1'b1);
    chk_reg("p0_count", 2'd2, 32'd0);

    // MODE = 10 behaves as one-shot.
    wr(2'd1, 32'd2);
    chk_irq("m10_pclr", 1'b0);
    wr(2'd0, 32'hD);
`ifdef PRESET_TIMER_AUTO_RELOAD_EN
    chk_reg("m10_ctrl", 2'd0, 32'hD);
`else
    chk_reg("m10_ctrl", 2'd0, 32'h9);
`endif
    step(4);
    chk_irq("m10_e4_irq", 1'b1);
    step(1);
`ifdef PRESET_TIMER_AUTO_RELOAD_EN
    chk_reg("m10_en_clr", 2'd0, 32'hC);
`else
    chk_reg("m10_en_clr", 2'd0, 32'h8);
`endif
    step(3);
    chk_reg("m10_no_reload", 2'd2, 32'd0);
    chk_irq("m10_irq_hold", 1'b1);

    // Illegal accesses.
    wr(2'd2, 32'hDEAD_BEEF);
    wr(2'd3, 32'h1234_5678);
    chk_reg("ill_count", 2'd2, 32'd0);
    chk_reg("ill_addr3", 2'd3, 32'd0);
    chk_reg("ill_preset", 2'd1, 32'd2);
    chk_irq("ill_irq_hold", 1'b1);

    // Mode 01: auto-reload when built in, one-shot otherwise.
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hB);
`ifdef PRESET_TIMER_AUTO_RELOAD_EN
    chk_reg("ar_ctrl", 2'd0, 32'hB);
    step(1);
    for (int k = 2; k <= 12; k++) begin
      int p;
      step(1);
      p = (k - 2) % 5;
      chk_reg($sformatf("ar_count_e%0d", k), 2'd2, 32'(4 - p));
      chk_irq($sformatf("ar_irq_e%0d", k), p == 4);
    end
    wr(2'd0, 32'h0);
    step(2);
`else
    chk_reg("ar_ctrl", 2'd0, 32'h9);
    step(6);
    chk_irq("ar_os_e6_irq", 1'b1);
    step(1);
    chk_reg("ar_os_count", 2'd2, 32'd0);
    chk_reg("ar_os_en_clr", 2'd0, 32'h8);
    chk_irq("ar_os_irq_hold", 1'b1);
`endif

    // Asynchronous reset mid-count.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(5);
    chk_reg("ar_pre_count", 2'd2, 32'd7);
    #1 rst = 1'b0;
    chk_reg("arst_count", 2'd2, 32'd0);
    chk_reg("arst_ctrl", 2'd0, 32'd0);
    chk_reg("arst_preset", 2'd1, 32'd0);
    chk_irq("arst_irq", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(3);
    chk_reg("post_rst_count", 2'd2, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
